game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//   Top-level game controller for the pipe/bird datapath. Generates the frame-rate
//   step enable for the pipe position and bird physics blocks, and sequences the
//   IDLE/PLAY/GAME_OVER flow. Schedules pipe respawns, keeps the score and enforces
//   a post-death lockout. Sits between the button inputs and the position datapath.
// PARAMETERS
//   TICK_DIV     416666  clk cycles per game step (60 Hz at 25 MHz); >=2
//   BIRD_X       100     bird left edge x, pixels
//   PIPE_W       40      pipe width, pixels
//   PIPE_STEP    20      pixels the pipe moves per step (must match datapath)
//   DEATH_HOLD   60      steps of GAME_OVER lockout before restart is accepted
// PORTS
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-high reset
//   start_button  in   1   debounced level; rising edge = start/restart request
//   collided      in   1   level from collision detector, valid every cycle
//   pipe_x        in   10  current pipe x from position datapath
//   step_en       out  1   1-cycle pulse per game step, only in PLAY
//   pipe_respawn  out  1   1-cycle pulse: datapath reloads pipe x/y
//   state         out  2   00 IDLE, 01 PLAY, 10 GAME_OVER
//   score         out  8   pipes passed, saturates at 255
//   game_over     out  1   high while state==GAME_OVER
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, score=0, step_en=0, pipe_respawn=0,
//     game_over=0, tick counter=0, hold counter=0, passed flag=0, start_q=0.
//     Reset mid-game aborts to IDLE the next cycle, regardless of state.
//   Tick: free-running counter 0..TICK_DIV-1; tick=1 for the cycle count==TICK_DIV-1,
//     then wraps to 0. Runs in every state. step_en = tick & (state==PLAY),
//     registered, so it lags tick by 1 cycle.
//   start_rise = start_button & ~start_q; start_q registers start_button every cycle.
//   IDLE: on start_rise -> PLAY; same cycle assert pipe_respawn, score<=0, passed<=0.
//     A held button does not re-trigger.
//   PLAY, evaluated every cycle, priority order:
//     1 collided=1 -> GAME_OVER, hold<=DEATH_HOLD; no score or respawn that cycle.
//     2 on a tick cycle only, respawn check: pipe_x >= 10'd640+PIPE_W (offscreen or
//       wrapped below 0), or pipe_x < PIPE_STEP -> pipe_respawn pulse, passed<=0.
//     3 on a tick cycle only, score check: ~passed & (pipe_x+PIPE_W < BIRD_X), done in
//       11-bit arithmetic -> score<=sat(score+1), passed<=1. This check is skipped on
//       a cycle where a respawn fires.
//   GAME_OVER: step_en stays 0. hold decrements on each tick and stops at 0.
//     start_rise with hold==0 -> IDLE. start_rise with hold!=0 is ignored and is
//     not queued. score is frozen in GAME_OVER and kept until the next start.
//   state encoding 11 is illegal and goes to IDLE on the next cycle.
//   pipe_respawn is registered, 1 cycle wide, never asserted in two consecutive cycles.
// TESTING (TICK_DIV=4, DEATH_HOLD=3)
//   Reset mid-PLAY with score=5 -> next cycle state=00, score=0, step_en=0.
//   In IDLE, hold start_button high for 20 cycles -> one PLAY entry, one
//     pipe_respawn pulse, then step_en pulses every 4 cycles.
//   PLAY, pipe_x=50 on a tick (50+40<100) -> score 0->1; still 50 next tick -> stays 1;
//     with score=255 -> stays 255.
//   PLAY, pipe_x=10'd1010 on a tick -> pipe_respawn=1 for exactly 1 cycle, no score.
//   collided=1 on the same tick as a score condition -> state=10, score unchanged,
//     no step_en.
//   GAME_OVER: start_rise after 2 ticks -> ignored; start_rise after 3 ticks -> IDLE.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and its surroundings: button and
// collision inputs, pipe position in, step/respawn pulses and game status out.
interface game_sequencer_if;
    logic       start_button;
    logic       collided;
    logic [9:0] pipe_x;
    logic       step_en;
    logic       pipe_respawn;
    logic [1:0] state;
    logic [7:0] score;
    logic       game_over;

    modport master (
        output start_button, collided, pipe_x,
        input  step_en, pipe_respawn, state, score, game_over
    );

    modport slave (
        input  start_button, collided, pipe_x,
        output step_en, pipe_respawn, state, score, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// Game flow controller: frame-rate step generation, IDLE/PLAY/GAME_OVER sequencing,
// pipe respawn scheduling, score keeping and the post-death restart lockout.
module game_sequencer #(
    parameter int TICK_DIV   = 416666,
    parameter int BIRD_X     = 100,
    parameter int PIPE_W     = 40,
    parameter int PIPE_STEP  = 20,
    parameter int DEATH_HOLD = 60
) (
    input logic             clk,
    input logic             reset,
    game_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PLAY      = 2'b01,
        GAME_OVER = 2'b10,
        ILLEGAL   = 2'b11
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (DEATH_HOLD > 0) ? $clog2(DEATH_HOLD + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT   = HW'(DEATH_HOLD);
    localparam logic [9:0]    OFFSCREEN_X = 10'(640 + PIPE_W);
    localparam logic [9:0]    MIN_X       = 10'(PIPE_STEP);
    localparam logic [10:0]   BIRD_X11    = 11'(BIRD_X);
    localparam logic [10:0]   PIPE_W11    = 11'(PIPE_W);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    score_q, score_d;
    logic          passed_q, passed_d;
    logic          respawn_q, respawn_d;
    logic          step_q;
    logic          start_q;
    logic          start_rise;
    logic          pipe_offscreen;
    logic [10:0]   pipe_right;

    assign tick       = (tick_cnt == TICK_LAST);
    assign start_rise = bus.start_button & ~start_q;

    // A pipe that scrolled past the left edge wraps to a large unsigned x, so
    // both the "too far right" and "too close to zero" cases trigger a reload.
    assign pipe_offscreen = (bus.pipe_x >= OFFSCREEN_X) || (bus.pipe_x < MIN_X);
    assign pipe_right     = {1'b0, bus.pipe_x} + PIPE_W11;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        score_d   = score_q;
        passed_d  = passed_q;
        respawn_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d   = PLAY;
                    respawn_d = 1'b1;
                    score_d   = 8'd0;
                    passed_d  = 1'b0;
                end
            end

            PLAY: begin
                if (bus.collided) begin
                    state_d = GAME_OVER;
                    hold_d  = HOLD_INIT;
                end else if (tick) begin
                    if (pipe_offscreen) begin
                        respawn_d = 1'b1;
                        passed_d  = 1'b0;
                    end else if (!passed_q && (pipe_right < BIRD_X11)) begin
                        score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        passed_d = 1'b1;
                    end
                end
            end

            GAME_OVER: begin
                if (start_rise && (hold_q == '0)) begin
                    state_d = IDLE;
                end
                if (tick && (hold_q != '0)) begin
                    hold_d = hold_q - HW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The datapath reload is a single-cycle strobe; never let it stretch.
        if (respawn_q) begin
            respawn_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tick_cnt  <= '0;
            hold_q    <= '0;
            score_q   <= 8'd0;
            passed_q  <= 1'b0;
            respawn_q <= 1'b0;
            step_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            hold_q    <= hold_d;
            score_q   <= score_d;
            passed_q  <= passed_d;
            respawn_q <= respawn_d;
            step_q    <= tick && (state_q == PLAY) && (state_d == PLAY);
            start_q   <= bus.start_button;
        end
    end

    assign bus.state        = state_q;
    assign bus.score        = score_q;
    assign bus.step_en      = step_q;
    assign bus.pipe_respawn = respawn_q;
    assign bus.game_over    = (state_q == GAME_OVER);

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: directed stimulus queues expected events,
// a negedge monitor pops them whenever state, score or pipe_respawn changes.
module tb_game_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int DEATH_HOLD = 3;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam logic [9:0] PX_NEUTRAL = 10'd300;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [10:0] exp_q[$];
    string       name_q[$];

    logic [1:0] prev_state;
    logic [7:0] prev_score;
    int         mdl_cnt = 0;

    always #5 clk = ~clk;

    game_sequencer_if bus();

    game_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .BIRD_X    (100),
        .PIPE_W    (40),
        .PIPE_STEP (20),
        .DEATH_HOLD(DEATH_HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference tick phase: tells the stimulus which posedge is a game tick.
    always @(posedge clk) begin
        if (reset) mdl_cnt <= 0;
        else       mdl_cnt <= (mdl_cnt == TICK_DIV - 1) ? 0 : mdl_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input logic [1:0] st, input logic [7:0] sc, input logic rsp, input string name);
        exp_q.push_back({st, sc, rsp});
        name_q.push_back(name);
    endtask

    always @(negedge clk) begin
        if (mon_en && (bus.pipe_respawn !== 1'b0 || bus.state !== prev_state || bus.score !== prev_score)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got state=%0d score=%0d respawn=%0d, expected no event",
                         bus.state, bus.score, bus.pipe_respawn);
            end else begin
                checkOutput(name_q.pop_front(), {21'd0, bus.state, bus.score, bus.pipe_respawn},
                            {21'd0, exp_q.pop_front()});
            end
        end
        prev_state <= bus.state;
        prev_score <= bus.score;
    end

    task automatic applyStimulus(input logic [9:0] px, input logic col, input logic btn);
        bus.pipe_x       = px;
        bus.collided     = col;
        bus.start_button = btn;
    endtask

    // Returns at the negedge just before a tick posedge.
    task automatic waitTickEdge();
        @(negedge clk);
        while (mdl_cnt != TICK_DIV - 1) @(negedge clk);
    endtask

    task automatic tickWith(input logic [9:0] px, input logic col);
        waitTickEdge();
        applyStimulus(px, col, bus.start_button);
        @(negedge clk);
        applyStimulus(PX_NEUTRAL, 1'b0, bus.start_button);
    endtask

    task automatic pressButton();
        bus.start_button = 1'b1;
        @(negedge clk);
        bus.start_button = 1'b0;
        @(negedge clk);
    endtask

    task automatic countSteps(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.step_en === 1'b1) cnt++;
        end
    endtask

    initial begin
        int n;
        applyStimulus(PX_NEUTRAL, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_state", bus.state, ST_IDLE);
        checkOutput("reset_score", bus.score, 0);
        checkOutput("reset_step_en", bus.step_en, 0);
        checkOutput("reset_respawn", bus.pipe_respawn, 0);
        checkOutput("reset_game_over", bus.game_over, 0);
        mon_en = 1'b1;

        // Held button: one entry, one respawn, then a step every TICK_DIV cycles.
        expectEvent(ST_PLAY, 8'd0, 1'b1, "idle_to_play");
        bus.start_button = 1'b1;
        @(posedge clk);
        @(negedge clk);
        countSteps(20, n);
        checkOutput("step_pulses_in_20_cycles", n, 5);
        bus.start_button = 1'b0;

        expectEvent(ST_PLAY, 8'd1, 1'b0, "score_first_pass");
        tickWith(10'd50, 1'b0);
        tickWith(10'd50, 1'b0);
        checkOutput("score_no_double_count", bus.score, 1);

        expectEvent(ST_PLAY, 8'd1, 1'b1, "respawn_wrapped_x");
        tickWith(10'd1010, 1'b0);
        @(negedge clk);
        checkOutput("respawn_one_cycle", bus.pipe_respawn, 0);

        // x=10 would also score, but the respawn takes priority.
        for (int i = 2; i <= 5; i++) begin
            expectEvent(ST_PLAY, 8'(i), 1'b0, "score_build");
            tickWith(10'd50, 1'b0);
            expectEvent(ST_PLAY, 8'(i), 1'b1, "respawn_low_x");
            tickWith(10'd10, 1'b0);
        end
        checkOutput("score_before_reset", bus.score, 5);

        expectEvent(ST_IDLE, 8'd0, 1'b0, "reset_mid_play");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_state", bus.state, ST_IDLE);
        checkOutput("midreset_score", bus.score, 0);
        checkOutput("midreset_step_en", bus.step_en, 0);

        expectEvent(ST_PLAY, 8'd0, 1'b1, "restart_play");
        pressButton();
        for (int i = 1; i <= 255; i++) begin
            expectEvent(ST_PLAY, 8'(i), 1'b0, "score_ramp");
            tickWith(10'd50, 1'b0);
            expectEvent(ST_PLAY, 8'(i), 1'b1, "respawn_ramp");
            tickWith(10'd10, 1'b0);
        end
        tickWith(10'd50, 1'b0);
        checkOutput("score_saturated", bus.score, 255);

        expectEvent(ST_PLAY, 8'd255, 1'b1, "respawn_before_crash");
        tickWith(10'd10, 1'b0);
        expectEvent(ST_OVER, 8'd255, 1'b0, "collide_on_score_tick");
        tickWith(10'd50, 1'b1);
        checkOutput("crash_state", bus.state, ST_OVER);
        checkOutput("crash_game_over", bus.game_over, 1);
        checkOutput("crash_no_step", bus.step_en, 0);

        // Lockout: restart ignored until DEATH_HOLD ticks have elapsed.
        waitTickEdge();
        @(negedge clk);
        checkOutput("over_tick1_no_step", bus.step_en, 0);
        waitTickEdge();
        @(negedge clk);
        checkOutput("over_tick2_no_step", bus.step_en, 0);
        bus.start_button = 1'b1;
        @(negedge clk);
        bus.start_button = 1'b0;
        checkOutput("early_restart_ignored", bus.state, ST_OVER);
        waitTickEdge();
        @(negedge clk);
        checkOutput("over_tick3_no_step", bus.step_en, 0);
        checkOutput("over_still_locked", bus.state, ST_OVER);

        expectEvent(ST_IDLE, 8'd255, 1'b0, "over_to_idle");
        pressButton();
        checkOutput("score_kept_in_idle", bus.score, 255);
        checkOutput("idle_game_over_low", bus.game_over, 0);

        expectEvent(ST_PLAY, 8'd0, 1'b1, "play_clears_score");
        pressButton();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
